// File: rtl/alu_pkg.sv
// Shared opcode encoding and condition-code bit positions for the ALU.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_NOT  = 4'd5,
        OP_SHL  = 4'd6,
        OP_SHR  = 4'd7,
        OP_NOP  = 4'd8,
        OP_INC  = 4'd9,
        OP_DEC  = 4'd10,
        OP_PASS = 4'd11,
        OP_ADC  = 4'd12,
        OP_SBB  = 4'd13,
        OP_ROL  = 4'd14,
        OP_ROR  = 4'd15
    } alu_op_e;

    localparam int unsigned CC_N = 3;
    localparam int unsigned CC_Z = 2;
    localparam int unsigned CC_C = 1;
    localparam int unsigned CC_V = 0;

endpackage

// File: rtl/alu_datapath.sv
// Combinational ALU core: next result, next flags and a load strobe (low for hold opcodes).
// Rotates are built only when ALU_ROTATE_EN is defined; otherwise opcodes 14/15 hold.
module alu_datapath
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       n,
    input  logic             cin,
    output logic [WIDTH-1:0] res,
    output logic [3:0]       flags,
    output logic             load
);

    localparam int unsigned MSB = WIDTH - 1;

    logic [WIDTH-1:0] addend;
    logic             carry_in;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic             add_ovf;
    logic             sub_ovf;
    logic             c;
    logic             v;

    // INC/DEC reuse the add/sub paths with a constant one; ADC/SBB feed the stored carry.
    always_comb begin
        addend   = b;
        carry_in = 1'b0;
        case (alu_op_e'(n))
            OP_INC, OP_DEC: addend   = {{(WIDTH-1){1'b0}}, 1'b1};
            OP_ADC, OP_SBB: carry_in = cin;
            default: ;
        endcase
    end

    // The extra top bit of sum is carry-out; of diff it is borrow-out.
    assign sum  = {1'b0, a} + {1'b0, addend} + {{WIDTH{1'b0}}, carry_in};
    assign diff = {1'b0, a} - {1'b0, addend} - {{WIDTH{1'b0}}, carry_in};

    assign add_ovf = (a[MSB] == addend[MSB]) && (sum[MSB] != a[MSB]);
    assign sub_ovf = (a[MSB] != addend[MSB]) && (diff[MSB] != a[MSB]);

    always_comb begin
        res  = '0;
        c    = 1'b0;
        v    = 1'b0;
        load = 1'b1;
        case (alu_op_e'(n))
            OP_ADD, OP_INC, OP_ADC: begin
                res = sum[MSB:0];
                c   = sum[WIDTH];
                v   = add_ovf;
            end
            OP_SUB, OP_DEC, OP_SBB: begin
                res = diff[MSB:0];
                c   = diff[WIDTH];
                v   = sub_ovf;
            end
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_NOT:  res = ~a;
            OP_PASS: res = a;
            OP_SHL: begin
                res = {a[MSB-1:0], 1'b0};
                c   = a[MSB];
            end
            OP_SHR: begin
                res = {1'b0, a[MSB:1]};
                c   = a[0];
            end
`ifdef ALU_ROTATE_EN
            OP_ROL: begin
                res = {a[MSB-1:0], a[MSB]};
                c   = a[MSB];
            end
            OP_ROR: begin
                res = {a[0], a[MSB:1]};
                c   = a[0];
            end
`endif
            default: load = 1'b0;
        endcase
    end

    always_comb begin
        flags       = '0;
        flags[CC_N] = res[MSB];
        flags[CC_Z] = (res == '0);
        flags[CC_C] = c;
        flags[CC_V] = v;
    end

endmodule

// File: rtl/alu_unit.sv
// ALU with registered result and condition codes; NOP (and disabled rotates) hold state.
// Optional feature macro: ALU_ROTATE_EN enables ROL/ROR on opcodes 14/15.
module alu_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       n,
    output logic [3:0]       cc,
    output logic [WIDTH-1:0] tr
);

    logic [WIDTH-1:0] tr_q;
    logic [3:0]       cc_q;
    logic [WIDTH-1:0] res;
    logic [3:0]       flags;
    logic             load;

    alu_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .a     (a),
        .b     (b),
        .n     (n),
        .cin   (cc_q[CC_C]),
        .res   (res),
        .flags (flags),
        .load  (load)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tr_q <= '0;
            cc_q <= '0;
        end else if (load) begin
            tr_q <= res;
            cc_q <= flags;
        end
    end

    assign tr = tr_q;
    assign cc = cc_q;

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed vectors plus randomized ops against an
// integer-arithmetic reference model.
module tb_alu_unit;

    logic       clk;
    logic       rst_n;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] n;
    logic [3:0] cc;
    logic [7:0] tr;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_tr;
    logic [3:0] m_cc;

    alu_unit #(
        .WIDTH (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .n     (n),
        .cc    (cc),
        .tr    (tr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic, flags from sign/range rules.
    task automatic model_step(input logic [3:0] op, input logic [7:0] av, input logic [7:0] bv);
        int x, y, r, rr, ye, vk;
        logic c, v, ld, ci;
        x  = av;
        y  = bv;
        ci = m_cc[1];
        r  = 0;
        c  = 1'b0;
        ld = 1'b1;
        vk = 0;
        ye = y;
        case (op)
            4'd0:  begin r = x + y;        c = (r > 255); vk = 1; end
            4'd1:  begin r = x - y;        c = (r < 0);   vk = 2; end
            4'd2:  r = av & bv;
            4'd3:  r = av | bv;
            4'd4:  r = av ^ bv;
            4'd5:  r = 255 - x;
            4'd6:  begin r = x * 2;        c = (x >= 128); end
            4'd7:  begin r = x / 2;        c = (x % 2 == 1); end
            4'd8:  ld = 1'b0;
            4'd9:  begin r = x + 1;        c = (r > 255); vk = 1; ye = 1; end
            4'd10: begin r = x - 1;        c = (r < 0);   vk = 2; ye = 1; end
            4'd11: r = x;
            4'd12: begin r = x + y + ci;   c = (r > 255); vk = 1; end
            4'd13: begin r = x - y - ci;   c = (r < 0);   vk = 2; end
`ifdef ALU_ROTATE_EN
            4'd14: begin r = (x * 2) % 256 + x / 128;  c = (x >= 128); end
            4'd15: begin r = x / 2 + (x % 2) * 128;    c = (x % 2 == 1); end
`else
            default: ld = 1'b0;
`endif
        endcase
        rr = ((r % 256) + 256) % 256;
        v  = 1'b0;
        if (vk == 1) v = ((x >= 128) == (ye >= 128)) && ((rr >= 128) != (x >= 128));
        if (vk == 2) v = ((x >= 128) != (ye >= 128)) && ((rr >= 128) != (x >= 128));
        if (ld) begin
            m_tr = rr[7:0];
            m_cc = {(rr >= 128), (rr == 0), c, v};
        end
    endtask

    // Drive one operation, clock it in, advance the model, and settle 1 time unit past the edge.
    task automatic step(input logic [3:0] op, input logic [7:0] av, input logic [7:0] bv);
        n = op;
        a = av;
        b = bv;
        @(posedge clk);
        model_step(op, av, bv);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (tr !== 8'h00 || cc !== 4'h0) begin
            errors++;
            $display("FAIL reset_async tr=%h cc=%b required tr=00 cc=0000", tr, cc);
        end
        n = 4'd0;
        a = 8'h01;
        b = 8'h01;
        @(posedge clk);
        #1;
        checks++;
        if (tr !== 8'h00 || cc !== 4'h0) begin
            errors++;
            $display("FAIL reset_edge_ignored tr=%h cc=%b required tr=00 cc=0000", tr, cc);
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_tr = 8'h00;
        m_cc = 4'h0;
    endtask

    task automatic test_directed;
        step(4'd0, 8'h7F, 8'h01);
        checks++;
        if (tr !== 8'h80 || cc !== 4'b1001) begin
            errors++;
            $display("FAIL add_ovf tr=%h cc=%b required tr=80 cc=1001", tr, cc);
        end
        step(4'd1, 8'h05, 8'h05);
        checks++;
        if (tr !== 8'h00 || cc !== 4'b0100) begin
            errors++;
            $display("FAIL sub_zero tr=%h cc=%b required tr=00 cc=0100", tr, cc);
        end
        step(4'd1, 8'h00, 8'h01);
        checks++;
        if (tr !== 8'hFF || cc !== 4'b1010) begin
            errors++;
            $display("FAIL sub_borrow tr=%h cc=%b required tr=ff cc=1010", tr, cc);
        end
        step(4'd0, 8'hFF, 8'h01);
        checks++;
        if (tr !== 8'h00 || cc !== 4'b0110) begin
            errors++;
            $display("FAIL add_carry tr=%h cc=%b required tr=00 cc=0110", tr, cc);
        end
        step(4'd12, 8'h10, 8'h20);
        checks++;
        if (tr !== 8'h31 || cc !== 4'b0000) begin
            errors++;
            $display("FAIL adc_cin tr=%h cc=%b required tr=31 cc=0000", tr, cc);
        end
        step(4'd8, 8'hAA, 8'h55);
        checks++;
        if (tr !== 8'h31 || cc !== 4'b0000) begin
            errors++;
            $display("FAIL nop_hold tr=%h cc=%b required tr=31 cc=0000", tr, cc);
        end
        step(4'd6, 8'h81, 8'h00);
        checks++;
        if (tr !== 8'h02 || cc !== 4'b0010) begin
            errors++;
            $display("FAIL shl tr=%h cc=%b required tr=02 cc=0010", tr, cc);
        end
        step(4'd14, 8'h81, 8'h00);
        checks++;
`ifdef ALU_ROTATE_EN
        if (tr !== 8'h03 || cc !== 4'b0010) begin
            errors++;
            $display("FAIL rol tr=%h cc=%b required tr=03 cc=0010", tr, cc);
        end
`else
        if (tr !== 8'h02 || cc !== 4'b0010) begin
            errors++;
            $display("FAIL rol_hold tr=%h cc=%b required tr=02 cc=0010", tr, cc);
        end
`endif
        step(4'd1, 8'h00, 8'h01);
        step(4'd13, 8'h00, 8'h00);
        checks++;
        if (tr !== 8'hFF || cc !== 4'b1010) begin
            errors++;
            $display("FAIL sbb_borrow tr=%h cc=%b required tr=ff cc=1010", tr, cc);
        end
        step(4'd10, 8'h80, 8'h00);
        checks++;
        if (tr !== 8'h7F || cc !== 4'b0001) begin
            errors++;
            $display("FAIL dec_ovf tr=%h cc=%b required tr=7f cc=0001", tr, cc);
        end
    endtask

    task automatic test_operand_change;
        step(4'd4, 8'h3C, 8'h0F);
        for (int i = 0; i < 3; i++) begin
            n = 4'($urandom_range(0, 15));
            a = 8'($urandom);
            b = 8'($urandom);
            #2;
            checks++;
            if (tr !== m_tr || cc !== m_cc) begin
                errors++;
                $display("FAIL no_edge_change tr=%h cc=%b required tr=%h cc=%b",
                         tr, cc, m_tr, m_cc);
            end
        end
    endtask

    task automatic test_random;
        logic [3:0] op;
        logic [7:0] av;
        logic [7:0] bv;
        for (int i = 0; i < 400; i++) begin
            op = 4'($urandom_range(0, 15));
            av = 8'($urandom);
            bv = 8'($urandom);
            if (i % 16 == 0) av = 8'h7F;
            if (i % 16 == 1) av = 8'h80;
            step(op, av, bv);
            checks++;
            if (tr !== m_tr || cc !== m_cc) begin
                errors++;
                $display("FAIL random op=%0d a=%h b=%h tr=%h cc=%b required tr=%h cc=%b",
                         op, av, bv, tr, cc, m_tr, m_cc);
            end
        end
    endtask

    task automatic test_async_reset;
        step(4'd1, 8'h00, 8'h01);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (tr !== 8'h00 || cc !== 4'h0) begin
            errors++;
            $display("FAIL midcycle_reset tr=%h cc=%b required tr=00 cc=0000", tr, cc);
        end
        m_tr = 8'h00;
        m_cc = 4'h0;
        n = 4'd12;
        a = 8'h10;
        b = 8'h20;
        @(negedge clk);
        rst_n = 1'b1;
        step(4'd12, 8'h10, 8'h20);
        checks++;
        if (tr !== 8'h30 || cc !== 4'b0000) begin
            errors++;
            $display("FAIL post_reset_adc tr=%h cc=%b required tr=30 cc=0000", tr, cc);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        a = 8'h00;
        b = 8'h00;
        n = 4'd8;
        m_tr = 8'h00;
        m_cc = 4'h0;
        test_reset();
        test_directed();
        test_operand_change();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
